// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per shift+trial cycle pair.
// Revision 1.0
`default_nettype none

module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TRIAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [CNT_W-1:0] cnt;
  logic             dbz;
  logic             accept;
  logic             zero_div;

  assign accept   = (state == IDLE) && start_i;
  assign zero_div = (divisor_i == '0);
  // One extra remainder bit keeps the trial subtraction exact when the divisor MSB is set.
  assign diff     = rem - {1'b0, dvs};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_nxt = zero_div ? DONE : SHIFT;
        end
      end
      SHIFT: state_nxt = TRIAL;
      TRIAL: state_nxt = (cnt == LAST_BIT) ? DONE : SHIFT;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
      dbz <= 1'b0;
    end else begin
      if (accept) begin
        if (zero_div) begin
          quo <= '1;
          rem <= {1'b0, dividend_i};
          dbz <= 1'b1;
        end else begin
          rem <= '0;
          quo <= dividend_i;
          dvs <= divisor_i;
          cnt <= '0;
          dbz <= 1'b0;
        end
      end else if (state == SHIFT) begin
        rem <= {rem[WIDTH-1:0], quo[WIDTH-1]};
        quo <= {quo[WIDTH-2:0], 1'b0};
      end else if (state == TRIAL) begin
        // A negative trial result restores simply by leaving R and Q untouched.
        if (!diff[WIDTH]) begin
          rem    <= diff;
          quo[0] <= 1'b1;
        end
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign busy_o        = (state != IDLE);
  assign done_o        = (state == DONE);
  assign quotient_o    = quo;
  assign remainder_o   = rem[WIDTH-1:0];
  assign div_by_zero_o = dbz;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized scoreboard bench for seq_divider against an arithmetic reference model.
// Revision 1.0
`default_nettype none

module tb_seq_divider;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dbz;

  seq_divider #(.WIDTH(W)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .busy_o       (busy),
    .done_o       (done),
    .quotient_o   (quotient),
    .remainder_o  (remainder),
    .div_by_zero_o(dbz)
  );

  typedef struct {
    int           exp_cyc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } item_t;

  item_t sb[$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    idle_cyc = 0;
  int    acc_cyc  = 0;
  logic  check_idle_next = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: plain unsigned division, with the divide-by-zero convention.
  function automatic item_t model(logic [W-1:0] a, logic [W-1:0] b, int acc);
    item_t e;
    e.a = a;
    e.b = b;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
      e.exp_cyc = acc;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
      e.exp_cyc = acc + 2 * W;
    end
    return e;
  endfunction

  // Assumes the caller sits just after a negedge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    item_t e;
    while (cyc < idle_cyc) @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    e = model(a, b, acc_cyc);
    sb.push_back(e);
    idle_cyc = e.exp_cyc + 1;
    chk("busy_rise", {63'd0, busy}, 64'd1);
  endtask

  // noise: 0 quiet, 1 directed 50/5 pulses, 2 random start pulses with random operands.
  task automatic wait_idle(input int noise);
    forever begin
      @(negedge clk);
      if (cyc >= idle_cyc) break;
      dividend = $urandom;
      divisor  = $urandom;
      start    = 1'b0;
      if (noise == 1 && (cyc == acc_cyc + 10 || cyc == acc_cyc + 64 || cyc == idle_cyc - 1)) begin
        start    = 1'b1;
        dividend = 50;
        divisor  = 5;
      end else if (noise == 2) begin
        start = ($urandom_range(0, 3) == 0);
      end
    end
  endtask

  task automatic gap(input int n);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_quot"}, {32'd0, quotient}, 64'd0);
    chk({tag, "_rem"},  {32'd0, remainder}, 64'd0);
    chk({tag, "_dbz"},  {63'd0, dbz}, 64'd0);
  endtask

  always @(negedge clk) begin
    item_t e;
    if (rst_n) begin
      if (check_idle_next) begin
        chk("busy_fall", {63'd0, busy}, 64'd0);
        check_idle_next = 1'b0;
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("latency_cyc", 64'(cyc), 64'(e.exp_cyc));
          chk("quotient",    {32'd0, quotient}, {32'd0, e.q});
          chk("remainder",   {32'd0, remainder}, {32'd0, e.r});
          chk("div_by_zero", {63'd0, dbz}, {63'd0, e.z});
          chk("busy_in_done", {63'd0, busy}, 64'd1);
          if (!e.z) begin
            chk("invariant", 64'(quotient) * 64'(e.b) + 64'(remainder), 64'(e.a));
            chk("rem_lt_div", {63'd0, (remainder < e.b)}, 64'd1);
          end
          check_idle_next = 1'b1;
        end
      end else if (sb.size() > 0 && cyc > sb[0].exp_cyc) begin
        chk("missing_done", 64'd0, 64'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           sel;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    idle_cyc = cyc;

    issue(100, 7);                          wait_idle(0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);    wait_idle(0);
    issue(32'hFFFF_FFFF, 32'd1);            wait_idle(0);
    issue(32'h8000_0000, 32'h8000_0001);    wait_idle(0);
    issue(5, 0);                            wait_idle(0);
    issue(9, 4);                            wait_idle(0);
    issue(3, 10);                           wait_idle(1);
    issue(50, 5);                           wait_idle(0);

    issue(1000, 3);
    while (cyc < acc_cyc + 30) @(negedge clk);
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    sb.delete();
    check_idle_next = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    idle_cyc = cyc;
    issue(1000, 3);                         wait_idle(0);

    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        a = $urandom;
        b = '0;
      end else if (sel <= 2) begin
        a = $urandom >> 16;
        b = a + 1 + ($urandom >> 17);
      end else begin
        a = $urandom >> $urandom_range(0, 31);
        b = $urandom >> $urandom_range(0, 31);
        if (b == '0) b = 1;
      end
      issue(a, b);
      wait_idle(($urandom_range(0, 1) == 0) ? 2 : 0);
      if ($urandom_range(0, 1) == 0) gap($urandom_range(1, 3));
    end

    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
